usb3_in_arb: RTL and testbench

USB3_IN_ARB -- requirements
Module: usb3_in_arb

---
 rtl/usb3_in_arb.sv | 200 ++++++++++++++++++++
 tb/tb_usb3_in_arb.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb3_in_arb.sv
// usb3_in_arb
// Arbitrates NUM_CH IN-endpoint producers onto one downstream IN buffer.
// One channel at a time owns the buffer write port from grant until its packet
// is committed and acknowledged, it drops its request, or the watchdog fires.
//
// Ports
//   clk, reset_n        : clock (rising edge), async active-low reset
//   ch_req/ch_gnt       : per-channel request, one-hot (or zero) grant
//   ch_addr/ch_data/
//   ch_wren             : per-channel packed write port, slice i = channel i
//   ch_commit/
//   ch_commit_len/
//   ch_commit_ack       : per-channel commit request, length, 1-cycle ack
//   buf_in_ready        : downstream buffer free (looked at only in IDLE)
//   buf_in_addr/data/
//   buf_in_wren         : muxed write port, live only while in GRANT
//   buf_in_commit/
//   buf_in_commit_len/
//   buf_in_commit_ack   : downstream commit handshake
//   cur_ch              : index of the granted channel
//   busy                : FSM not in IDLE
//   timeout_err         : 1-cycle pulse in the cycle the watchdog revokes a grant
//
// ch_commit_ack is registered: it pulses in the IDLE cycle right after the
// downstream ack edge, together with the drop of buf_in_commit and ch_gnt.
module usb3_in_arb #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 11,
    parameter int TIMEOUT = 1024,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        ch_req,
    output logic [NUM_CH-1:0]        ch_gnt,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_wren,
    input  logic [NUM_CH-1:0]        ch_commit,
    input  logic [NUM_CH*LEN_W-1:0]  ch_commit_len,
    output logic [NUM_CH-1:0]        ch_commit_ack,
    input  logic                     buf_in_ready,
    output logic [ADDR_W-1:0]        buf_in_addr,
    output logic [DATA_W-1:0]        buf_in_data,
    output logic                     buf_in_wren,
    output logic                     buf_in_commit,
    output logic [LEN_W-1:0]         buf_in_commit_len,
    input  logic                     buf_in_commit_ack,
    output logic [CH_W-1:0]          cur_ch,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, COMMIT} state_t;

    state_t state, state_nxt;

    // Per-channel views of the packed buses.
    logic [NUM_CH-1:0][ADDR_W-1:0] addr_a;
    logic [NUM_CH-1:0][DATA_W-1:0] data_a;
    logic [NUM_CH-1:0][LEN_W-1:0]  len_a;

    assign addr_a = ch_addr;
    assign data_a = ch_data;
    assign len_a  = ch_commit_len;

    logic [CH_W-1:0]   last_ch;
    logic [CH_W-1:0]   pick;
    logic              pick_vld;
    logic [CH_W:0]     sum;
    logic [NUM_CH-1:0] pick_oh;
    logic [NUM_CH-1:0] cur_oh;
    logic [WD_W-1:0]   wdog;

    logic start_gnt;
    logic take_commit;
    logic end_gnt;
    logic g_commit;
    logic g_req;
    logic wd_exp;

    // Round-robin search starting at last_ch+1. Scanning from the farthest
    // offset down lets the nearest requester overwrite earlier hits.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        sum      = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            sum = {1'b0, last_ch} + (CH_W+1)'(k);
            if (sum >= (CH_W+1)'(NUM_CH))
                sum = sum - (CH_W+1)'(NUM_CH);
            if (ch_req[sum[CH_W-1:0]]) begin
                pick     = sum[CH_W-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    assign pick_oh  = NUM_CH'(1) << pick;
    assign cur_oh   = NUM_CH'(1) << cur_ch;
    assign g_commit = ch_commit[cur_ch];
    assign g_req    = ch_req[cur_ch];
    assign wd_exp   = (wdog == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and control strobes. Within GRANT a commit wins over both an
    // abandon and a watchdog expiry in the same cycle.
    always_comb begin
        state_nxt   = state;
        start_gnt   = 1'b0;
        take_commit = 1'b0;
        end_gnt     = 1'b0;
        timeout_err = 1'b0;
        case (state)
            IDLE: begin
                if (buf_in_ready && pick_vld) begin
                    start_gnt = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (g_commit) begin
                    take_commit = 1'b1;
                    state_nxt   = COMMIT;
                end else if (!g_req) begin
                    end_gnt   = 1'b1;
                    state_nxt = IDLE;
                end else if (wd_exp) begin
                    end_gnt     = 1'b1;
                    timeout_err = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            COMMIT: begin
                if (buf_in_commit_ack) begin
                    end_gnt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_gnt            <= '0;
            ch_commit_ack     <= '0;
            buf_in_commit     <= 1'b0;
            buf_in_commit_len <= '0;
            cur_ch            <= '0;
            wdog              <= '0;
            last_ch           <= CH_W'(NUM_CH - 1);
        end else begin
            ch_commit_ack <= '0;
            if (start_gnt) begin
                ch_gnt <= pick_oh;
                cur_ch <= pick;
                wdog   <= '0;
            end else if (state == GRANT) begin
                wdog <= wdog + WD_W'(1);
            end
            if (take_commit) begin
                buf_in_commit     <= 1'b1;
                buf_in_commit_len <= len_a[cur_ch];
            end
            if (end_gnt) begin
                ch_gnt        <= '0;
                buf_in_commit <= 1'b0;
                last_ch       <= cur_ch;
                if (state == COMMIT)
                    ch_commit_ack <= cur_oh;
            end
        end
    end

    // Write port is a pure mux of the owner; parked at zero outside GRANT.
    always_comb begin
        buf_in_wren = 1'b0;
        buf_in_addr = '0;
        buf_in_data = '0;
        if (state == GRANT) begin
            buf_in_wren = ch_wren[cur_ch];
            buf_in_addr = addr_a[cur_ch];
            buf_in_data = data_a[cur_ch];
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_usb3_in_arb.sv
module tb_usb3_in_arb;

    localparam int NCH = 4;
    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int LW  = 11;
    localparam int TO  = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic [NCH-1:0]         ch_req;
    logic [NCH-1:0]         ch_wren;
    logic [NCH-1:0]         ch_commit;
    logic [NCH-1:0][AW-1:0] a_addr;
    logic [NCH-1:0][DW-1:0] a_data;
    logic [NCH-1:0][LW-1:0] a_len;
    logic                   buf_in_ready;
    logic                   buf_in_commit_ack;

    logic [NCH-1:0] ch_gnt;
    logic [NCH-1:0] ch_commit_ack;
    logic [AW-1:0]  buf_in_addr;
    logic [DW-1:0]  buf_in_data;
    logic           buf_in_wren;
    logic           buf_in_commit;
    logic [LW-1:0]  buf_in_commit_len;
    logic [1:0]     cur_ch;
    logic           busy;
    logic           timeout_err;

    usb3_in_arb #(
        .NUM_CH (NCH),
        .ADDR_W (AW),
        .DATA_W (DW),
        .LEN_W  (LW),
        .TIMEOUT(TO)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .ch_req           (ch_req),
        .ch_gnt           (ch_gnt),
        .ch_addr          (a_addr),
        .ch_data          (a_data),
        .ch_wren          (ch_wren),
        .ch_commit        (ch_commit),
        .ch_commit_len    (a_len),
        .ch_commit_ack    (ch_commit_ack),
        .buf_in_ready     (buf_in_ready),
        .buf_in_addr      (buf_in_addr),
        .buf_in_data      (buf_in_data),
        .buf_in_wren      (buf_in_wren),
        .buf_in_commit    (buf_in_commit),
        .buf_in_commit_len(buf_in_commit_len),
        .buf_in_commit_ack(buf_in_commit_ack),
        .cur_ch           (cur_ch),
        .busy             (busy),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboards: expected grant order and expected buffer writes.
    int               exp_gnt_q[$];
    logic [AW+DW-1:0] exp_wr_q[$];

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a commit from channel ch, optionally drop all requests once it is
    // taken, then answer the downstream commit with a 1-cycle ack. Returns in
    // the IDLE cycle right after the ack edge.
    task automatic finish_commit(input int ch, input int len, input bit drop_req);
        ch_commit[ch] = 1'b1;
        a_len[ch]     = LW'(len);
        step();
        ch_commit = '0;
        if (drop_req) ch_req = '0;
        buf_in_commit_ack = 1'b1;
        step();
        buf_in_commit_ack = 1'b0;
    endtask

    task automatic check_grant(input string name);
        int e;
        e = exp_gnt_q.pop_front();
        n_cmp++;
        if (ch_gnt !== NCH'(1 << e) || cur_ch !== 2'(e)) begin
            n_bad++;
            $display("FAIL %s: got ch_gnt=%b cur_ch=%0d, want ch_gnt=%b cur_ch=%0d",
                     name, ch_gnt, cur_ch, NCH'(1 << e), e);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        n_cmp++;
        if (ch_gnt !== '0 || cur_ch !== '0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_gnt: got ch_gnt=%b cur_ch=%0d busy=%b, want 0/0/0", ch_gnt, cur_ch, busy);
        end
        n_cmp++;
        if (buf_in_commit !== 1'b0 || buf_in_commit_len !== '0 || ch_commit_ack !== '0) begin
            n_bad++;
            $display("FAIL reset_commit: got commit=%b len=%0d ack=%b, want 0/0/0",
                     buf_in_commit, buf_in_commit_len, ch_commit_ack);
        end
        n_cmp++;
        if (timeout_err !== 1'b0 || buf_in_wren !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_misc: got timeout_err=%b wren=%b, want 0/0", timeout_err, buf_in_wren);
        end
        reset_n = 1'b1;
        step();
    endtask

    // All four channels requesting, every commit acked at once.
    task automatic test_round_robin();
        int e;
        buf_in_ready = 1'b1;
        ch_req = '1;
        for (int i = 0; i < 5; i++) exp_gnt_q.push_back(i % NCH);
        step();
        for (int g = 0; g < 5; g++) begin
            e = exp_gnt_q[0];
            check_grant("rr_order");
            finish_commit(e, 4 * (g + 1), 1'b0);
            if (g == 4) ch_req = '0;
            n_cmp++;
            if (ch_commit_ack !== NCH'(1 << e) || ch_gnt !== '0) begin
                n_bad++;
                $display("FAIL rr_ack: got ack=%b gnt=%b, want ack=%b gnt=0000",
                         ch_commit_ack, ch_gnt, NCH'(1 << e));
            end
            step();
            n_cmp++;
            if (ch_commit_ack !== '0) begin
                n_bad++;
                $display("FAIL rr_ack_width: got ack=%b one cycle later, want 0000", ch_commit_ack);
            end
        end
    endtask

    // Channel 2: three writes then a 12-byte commit, downstream slow to ack.
    task automatic test_writes();
        logic [AW+DW-1:0] w;
        ch_req = 4'b0100;
        exp_gnt_q.push_back(2);
        step();
        check_grant("wr_grant");
        for (int i = 0; i < 3; i++) begin
            a_addr[2]  = AW'(i);
            a_data[2]  = 32'hA5A5_0000 + 32'(i);
            ch_wren[2] = 1'b1;
            exp_wr_q.push_back({AW'(i), 32'hA5A5_0000 + 32'(i)});
            #1;
            w = exp_wr_q.pop_front();
            n_cmp++;
            if (buf_in_wren !== 1'b1 || {buf_in_addr, buf_in_data} !== w) begin
                n_bad++;
                $display("FAIL wr_pass: got wren=%b addr=%0h data=%h, want wren=1 addr=%0h data=%h",
                         buf_in_wren, buf_in_addr, buf_in_data, w[AW+DW-1:DW], w[DW-1:0]);
            end
            step();
        end
        ch_wren = '0;
        ch_commit[2] = 1'b1;
        a_len[2] = LW'(12);
        step();
        ch_commit = '0;
        ch_req = '0;
        n_cmp++;
        if (buf_in_commit !== 1'b1 || buf_in_commit_len !== LW'(12)) begin
            n_bad++;
            $display("FAIL wr_commit: got commit=%b len=%0d, want 1/12", buf_in_commit, buf_in_commit_len);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (buf_in_commit !== 1'b1 || buf_in_commit_len !== LW'(12) || ch_commit_ack !== '0 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL wr_hold: got commit=%b len=%0d ack=%b busy=%b, want 1/12/0000/1",
                         buf_in_commit, buf_in_commit_len, ch_commit_ack, busy);
            end
        end
        buf_in_commit_ack = 1'b1;
        step();
        buf_in_commit_ack = 1'b0;
        n_cmp++;
        if (ch_commit_ack !== 4'b0100 || buf_in_commit !== 1'b0 || ch_gnt !== '0) begin
            n_bad++;
            $display("FAIL wr_ack: got ack=%b commit=%b gnt=%b, want 0100/0/0000",
                     ch_commit_ack, buf_in_commit, ch_gnt);
        end
        step();
    endtask

    // Write and commit in the same cycle, zero-length commit.
    task automatic test_wren_commit_same_cycle();
        logic [AW+DW-1:0] w;
        ch_req = 4'b0010;
        exp_gnt_q.push_back(1);
        step();
        check_grant("same_grant");
        a_addr[1] = 9'h1F0;
        a_data[1] = 32'hDEAD_BEEF;
        ch_wren[1] = 1'b1;
        ch_commit[1] = 1'b1;
        a_len[1] = '0;
        exp_wr_q.push_back({9'h1F0, 32'hDEAD_BEEF});
        #1;
        w = exp_wr_q.pop_front();
        n_cmp++;
        if (buf_in_wren !== 1'b1 || {buf_in_addr, buf_in_data} !== w) begin
            n_bad++;
            $display("FAIL same_wr: got wren=%b addr=%0h data=%h, want wren=1 addr=%0h data=%h",
                     buf_in_wren, buf_in_addr, buf_in_data, w[AW+DW-1:DW], w[DW-1:0]);
        end
        step();
        ch_wren = '0;
        ch_commit = '0;
        ch_req = '0;
        n_cmp++;
        if (buf_in_commit !== 1'b1 || buf_in_commit_len !== '0) begin
            n_bad++;
            $display("FAIL same_commit: got commit=%b len=%0d, want 1/0", buf_in_commit, buf_in_commit_len);
        end
        buf_in_commit_ack = 1'b1;
        step();
        buf_in_commit_ack = 1'b0;
        step();
    endtask

    // ch 2 sits on its grant; watchdog revokes it, ch 0 is next. Then ch 0
    // abandons its grant by dropping the request.
    task automatic test_timeout_and_abandon();
        ch_req = 4'b0101;
        exp_gnt_q.push_back(2);
        exp_gnt_q.push_back(0);
        step();
        check_grant("to_grant");
        for (int c = 1; c <= TO; c++) begin
            n_cmp++;
            if (timeout_err !== (c == TO) || ch_gnt !== 4'b0100) begin
                n_bad++;
                $display("FAIL to_pulse: grant cycle %0d got timeout_err=%b gnt=%b, want %b/0100",
                         c, timeout_err, ch_gnt, (c == TO));
            end
            if (c < TO) step();
        end
        step();
        n_cmp++;
        if (ch_gnt !== '0 || timeout_err !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL to_revoke: got gnt=%b timeout_err=%b busy=%b, want 0000/0/0", ch_gnt, timeout_err, busy);
        end
        step();
        check_grant("to_next");
        ch_req = '0;
        #1;
        n_cmp++;
        if (timeout_err !== 1'b0) begin
            n_bad++;
            $display("FAIL abandon_err: got timeout_err=%b, want 0", timeout_err);
        end
        step();
        n_cmp++;
        if (ch_gnt !== '0 || buf_in_commit !== 1'b0 || busy !== 1'b0 || ch_commit_ack !== '0) begin
            n_bad++;
            $display("FAIL abandon: got gnt=%b commit=%b busy=%b ack=%b, want 0000/0/0/0000",
                     ch_gnt, buf_in_commit, busy, ch_commit_ack);
        end
    endtask

    // No grant while the buffer is not ready; a later drop of ready is ignored.
    task automatic test_ready_gate();
        buf_in_ready = 1'b0;
        ch_req = '1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (ch_gnt !== '0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL rdy_block: got gnt=%b busy=%b, want 0000/0", ch_gnt, busy);
            end
        end
        buf_in_ready = 1'b1;
        exp_gnt_q.push_back(1);
        step();
        check_grant("rdy_grant");
        buf_in_ready = 1'b0;
        step();
        n_cmp++;
        if (ch_gnt !== 4'b0010 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rdy_drop: got gnt=%b busy=%b, want 0010/1", ch_gnt, busy);
        end
        finish_commit(1, 4, 1'b1);
        n_cmp++;
        if (ch_commit_ack !== 4'b0010) begin
            n_bad++;
            $display("FAIL rdy_ack: got ack=%b, want 0010", ch_commit_ack);
        end
        buf_in_ready = 1'b1;
        step();
    endtask

    // Writes and commits from a channel that does not own the grant.
    task automatic test_nongranted();
        logic [AW+DW-1:0] w;
        ch_req = 4'b0001;
        exp_gnt_q.push_back(0);
        step();
        check_grant("ng_grant");
        a_addr[1] = 9'h055;
        a_data[1] = 32'h1111_1111;
        ch_wren[1] = 1'b1;
        #1;
        n_cmp++;
        if (buf_in_wren !== 1'b0) begin
            n_bad++;
            $display("FAIL ng_wren_only: got wren=%b, want 0", buf_in_wren);
        end
        a_addr[0] = 9'h0AA;
        a_data[0] = 32'h2222_2222;
        ch_wren[0] = 1'b1;
        ch_commit[1] = 1'b1;
        exp_wr_q.push_back({9'h0AA, 32'h2222_2222});
        #1;
        w = exp_wr_q.pop_front();
        n_cmp++;
        if (buf_in_wren !== 1'b1 || {buf_in_addr, buf_in_data} !== w) begin
            n_bad++;
            $display("FAIL ng_mux: got wren=%b addr=%0h data=%h, want wren=1 addr=%0h data=%h",
                     buf_in_wren, buf_in_addr, buf_in_data, w[AW+DW-1:DW], w[DW-1:0]);
        end
        step();
        ch_wren = '0;
        ch_commit = '0;
        n_cmp++;
        if (buf_in_commit !== 1'b0 || ch_gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL ng_commit: got commit=%b gnt=%b, want 0/0001", buf_in_commit, ch_gnt);
        end
        finish_commit(0, 7, 1'b1);
        step();
    endtask

    // Reset in the middle of a commit; channel 0 wins first afterwards.
    task automatic test_reset_mid_commit();
        ch_req = 4'b1000;
        exp_gnt_q.push_back(3);
        step();
        check_grant("rst_grant");
        ch_commit[3] = 1'b1;
        a_len[3] = LW'(33);
        step();
        ch_commit = '0;
        ch_req = '0;
        n_cmp++;
        if (buf_in_commit !== 1'b1 || buf_in_commit_len !== LW'(33)) begin
            n_bad++;
            $display("FAIL rst_pre: got commit=%b len=%0d, want 1/33", buf_in_commit, buf_in_commit_len);
        end
        buf_in_commit_ack = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({ch_gnt, ch_commit_ack, buf_in_commit, buf_in_commit_len, cur_ch, busy, timeout_err, buf_in_wren} !== '0) begin
            n_bad++;
            $display("FAIL rst_async: got gnt=%b ack=%b commit=%b len=%0d cur=%0d busy=%b err=%b wren=%b, want all 0",
                     ch_gnt, ch_commit_ack, buf_in_commit, buf_in_commit_len, cur_ch, busy, timeout_err, buf_in_wren);
        end
        step();
        reset_n = 1'b1;
        step();
        n_cmp++;
        if (ch_commit_ack !== '0 || buf_in_commit !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_no_ack: got ack=%b commit=%b busy=%b, want 0000/0/0", ch_commit_ack, buf_in_commit, busy);
        end
        buf_in_commit_ack = 1'b0;
        ch_req = '1;
        exp_gnt_q.push_back(0);
        step();
        check_grant("rst_first");
        finish_commit(0, 1, 1'b1);
        step();
    endtask

    initial begin
        ch_req = '0;
        ch_wren = '0;
        ch_commit = '0;
        a_addr = '0;
        a_data = '0;
        a_len = '0;
        buf_in_ready = 1'b0;
        buf_in_commit_ack = 1'b0;
        test_reset();
        test_round_robin();
        test_writes();
        test_wren_commit_same_cycle();
        test_timeout_and_abandon();
        test_ready_gate();
        test_nongranted();
        test_reset_mid_commit();
        n_cmp++;
        if (exp_gnt_q.size() != 0 || exp_wr_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d grants / %0d writes left, want 0/0", exp_gnt_q.size(), exp_wr_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
